// File: rtl/nmi_periph_router_pkg.sv
// Shared types, constants and the address-decode helper for the NMI router.
package nmi_router_pkg;

   localparam int          SLV_MAX      = 16;
   localparam int          SEL_W        = 4;
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DERR = 2'd2
   } state_e;

   // One bit per slave window; only the first num entries can hit.
   function automatic logic [SLV_MAX-1:0] f_hit(
      input logic [31:0]               addr,
      input logic [SLV_MAX-1:0][31:0]  base,
      input logic [SLV_MAX-1:0][31:0]  mask,
      input int                        num
   );
      logic [SLV_MAX-1:0] hit;
      hit = '0;
      for (int i = 0; i < SLV_MAX; i++) begin
         if ((i < num) && ((addr & mask[i]) == base[i])) hit[i] = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/nmi_periph_router_if.sv
// NMI request/response bundle; master drives the request, slave answers.
interface nmi_if;
   logic        valid;
   logic        ready;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;

   modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
   modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/nmi_periph_router_tmo.sv
// FWD-state watchdog: counts forwarding cycles and flags expiry on the
// TIMEOUT_CYC-th one. Only built with NMI_ROUTER_TIMEOUT_EN.
module nmi_router_tmo #(
   parameter int TIMEOUT_CYC = 256
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic i_clr,
   input  logic i_en,
   output logic o_exp
);
   localparam int W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   logic [W-1:0] r_cnt;

   assign o_exp = i_en && (r_cnt == W'(TIMEOUT_CYC - 1));

   // Clear on FWD entry, count each FWD cycle, hold once expired.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                r_cnt <= '0;
      else if (i_clr)           r_cnt <= '0;
      else if (i_en && !o_exp)  r_cnt <= r_cnt + W'(1);
   end
endmodule

// File: rtl/nmi_periph_router.sv
// Registered, table-driven 1-to-N NMI router. The target slave is latched
// at acceptance; unmapped addresses get an error response.
// Optional feature macro: NMI_ROUTER_TIMEOUT_EN (answer hung slaves with an
// error after TIMEOUT_CYC forwarding cycles).
module nmi_periph_router
   import nmi_router_pkg::*;
#(
   parameter int                       SLV_NUM     = 11,
   parameter logic [SLV_NUM-1:0][31:0] SLV_BASE    = '0,
   parameter logic [SLV_NUM-1:0][31:0] SLV_MASK    = '0,
   parameter int                       TIMEOUT_CYC = 256,
   parameter logic [31:0]              ERR_DATA    = ERR_DATA_DEF
) (
   input  logic        clk_i,
   input  logic        rst_i,
   nmi_if.slave        nmi,
   nmi_if.master       slv_nmi [SLV_NUM],
   output logic        err_o,
   output logic [31:0] err_addr_o,
   output logic [7:0]  err_cnt_o
);
   // Tables padded to the maximum width so the decode helper is shape-fixed.
   localparam logic [SLV_MAX-1:0][31:0] BASE_PAD = (SLV_MAX*32)'(SLV_BASE);
   localparam logic [SLV_MAX-1:0][31:0] MASK_PAD = (SLV_MAX*32)'(SLV_MASK);

   if (SLV_NUM < 1 || SLV_NUM > SLV_MAX || TIMEOUT_CYC < 2) begin : g_cfg_bad
      $error("nmi_periph_router: SLV_NUM must be 1..16 and TIMEOUT_CYC >= 2");
   end

   state_e                    r_state, w_state_nxt;
   logic [SEL_W-1:0]          r_sel, w_hit_idx;
   logic [31:0]               r_addr;
   logic [SLV_MAX-1:0]        w_hit;
   logic [SLV_MAX-1:0]        w_slv_rdy;
   logic [SLV_MAX-1:0][31:0]  w_slv_rdata;
   logic                      w_sel_rdy;
   logic [31:0]               w_sel_rdata;
   logic                      w_in_fwd, w_fwd_act, w_go_fwd, w_tmo_exp;
   logic                      w_rdy, w_err;
   logic [31:0]               w_rdata;

   assign w_hit       = f_hit(nmi.addr, BASE_PAD, MASK_PAD, SLV_NUM);
   assign w_in_fwd    = (r_state == ST_FWD);
   // Gated by upstream valid so an aborting master drops slave valid at once.
   assign w_fwd_act   = w_in_fwd && nmi.valid;
   assign w_sel_rdy   = w_slv_rdy[r_sel];
   assign w_sel_rdata = w_slv_rdata[r_sel];

   // Lowest hit wins when windows overlap.
   always_comb begin
      w_hit_idx = '0;
      for (int i = SLV_MAX - 1; i >= 0; i--) begin
         if (w_hit[i]) w_hit_idx = SEL_W'(i);
      end
   end

   // Request fields broadcast; valid only to the latched target.
   for (genvar g = 0; g < SLV_MAX; g++) begin : g_slv
      if (g < SLV_NUM) begin : g_on
         assign slv_nmi[g].valid = w_fwd_act && (r_sel == SEL_W'(g));
         assign slv_nmi[g].addr  = nmi.addr;
         assign slv_nmi[g].wdata = nmi.wdata;
         assign slv_nmi[g].wstrb = nmi.wstrb;
         assign w_slv_rdy[g]     = slv_nmi[g].ready;
         assign w_slv_rdata[g]   = slv_nmi[g].rdata;
      end else begin : g_off
         assign w_slv_rdy[g]     = 1'b0;
         assign w_slv_rdata[g]   = '0;
      end
   end

`ifdef NMI_ROUTER_TIMEOUT_EN
   nmi_router_tmo #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .i_clr (w_go_fwd),
      .i_en  (w_in_fwd),
      .o_exp (w_tmo_exp)
   );
`else
   assign w_tmo_exp = 1'b0;
`endif

   // Next state plus the upstream response; slave ready beats expiry.
   always_comb begin
      w_state_nxt = r_state;
      w_go_fwd    = 1'b0;
      w_rdy       = 1'b0;
      w_rdata     = '0;
      w_err       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (nmi.valid) begin
               if (|w_hit) begin
                  w_state_nxt = ST_FWD;
                  w_go_fwd    = 1'b1;
               end else begin
                  w_state_nxt = ST_DERR;
               end
            end
         end
         ST_FWD: begin
            if (!nmi.valid) begin
               w_state_nxt = ST_IDLE;
            end else if (w_sel_rdy) begin
               w_rdy       = 1'b1;
               w_rdata     = w_sel_rdata;
               w_state_nxt = ST_IDLE;
            end else if (w_tmo_exp) begin
               w_rdy       = 1'b1;
               w_rdata     = ERR_DATA;
               w_err       = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         ST_DERR: begin
            w_rdy       = 1'b1;
            w_rdata     = ERR_DATA;
            w_err       = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign nmi.ready = w_rdy;
   assign nmi.rdata = w_rdata;
   assign err_o     = w_err;

   // State, target select and request address capture.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_sel   <= '0;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == ST_IDLE && nmi.valid) r_addr <= nmi.addr;
         if (w_go_fwd)                        r_sel  <= w_hit_idx;
      end
   end

   // Error log: last errored address and a saturating count.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_addr_o <= '0;
         err_cnt_o  <= '0;
      end else if (w_err) begin
         err_addr_o <= r_addr;
         if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      end
   end
endmodule

// File: tb/tb_nmi_periph_router.sv
// Randomized bench for nmi_periph_router against a transaction-level model.
module tb_nmi_periph_router;
   localparam int          N    = 3;
   localparam int          TMO  = 8;
   localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
   localparam logic [N-1:0][31:0] BASE    = {32'h4000_0000, 32'h1000_1000, 32'h1000_0000};
   localparam logic [N-1:0][31:0] MASK    = {32'hF000_0000, 32'hFF00_FF00, 32'hFF00_FF00};
   localparam logic [N-1:0][31:0] BASE_OV = {32'h2000_0000, 32'h3000_0000, 32'h2000_0000};
   localparam logic [N-1:0][31:0] MASK_OV = {32'hFF00_0000, 32'hF000_0000, 32'hF000_0000};
`ifdef NMI_ROUTER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nmi_if up ();
   nmi_if slv [N] ();
   nmi_if up_ov ();
   nmi_if slv_ov [N] ();

   logic        err, err_ov;
   logic [31:0] eaddr, eaddr_ov;
   logic [7:0]  ecnt, ecnt_ov;

   nmi_periph_router #(.SLV_NUM(N), .SLV_BASE(BASE), .SLV_MASK(MASK),
                       .TIMEOUT_CYC(TMO), .ERR_DATA(ERRD)) dut (
      .clk_i(clk), .rst_i(rst), .nmi(up), .slv_nmi(slv),
      .err_o(err), .err_addr_o(eaddr), .err_cnt_o(ecnt));

   nmi_periph_router #(.SLV_NUM(N), .SLV_BASE(BASE_OV), .SLV_MASK(MASK_OV),
                       .TIMEOUT_CYC(TMO), .ERR_DATA(ERRD)) dut_ov (
      .clk_i(clk), .rst_i(rst), .nmi(up_ov), .slv_nmi(slv_ov),
      .err_o(err_ov), .err_addr_o(eaddr_ov), .err_cnt_o(ecnt_ov));

   logic [N-1:0]        s_rdy, s_vld, ov_vld;
   logic [N-1:0][31:0]  s_data;
   logic [31:0]         b_addr, b_wdata;
   logic [3:0]          b_wstrb;

   for (genvar g = 0; g < N; g++) begin : g_slv
      assign slv[g].ready    = s_rdy[g];
      assign slv[g].rdata    = s_data[g];
      assign s_vld[g]        = slv[g].valid;
      assign slv_ov[g].ready = 1'b1;
      assign slv_ov[g].rdata = 32'hA000_0000 + g;
      assign ov_vld[g]       = slv_ov[g].valid;
   end
   assign b_addr  = slv[N-1].addr;
   assign b_wdata = slv[N-1].wdata;
   assign b_wstrb = slv[N-1].wstrb;

   int          checks = 0;
   int          errors = 0;
   int          s_lat [N];
   int          s_cnt [N];
   int          m_err_cnt = 0;
   logic [31:0] m_err_addr = '0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, act, exp);
      end
   endtask

   // Slave behaviour: ready after s_lat cycles of continuous valid.
   task automatic slv_step();
      for (int i = 0; i < N; i++) begin
         if (s_vld[i]) begin
            s_rdy[i] = (s_cnt[i] >= s_lat[i]);
            s_cnt[i]++;
         end else begin
            s_rdy[i] = 1'b0;
            s_cnt[i] = 0;
         end
      end
   endtask

   function automatic int ref_tgt(input logic [31:0] a, input logic [N-1:0][31:0] b,
                                  input logic [N-1:0][31:0] m);
      for (int i = 0; i < N; i++) if ((a & m[i]) == b[i]) return i;
      return -1;
   endfunction

   task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
      int          tgt, exp_cyc, got_cyc, bad;
      logic        is_err, got_err;
      logic [31:0] exp_rd, got_rd;
      logic [N-1:0] one, exp_v;
      one = 1;
      tgt = ref_tgt(a, BASE, MASK);
      if (tgt < 0) begin
         is_err = 1'b1; exp_cyc = 1; exp_rd = ERRD;
      end else if (TMO_EN && s_lat[tgt] > TMO - 1) begin
         is_err = 1'b1; exp_cyc = TMO; exp_rd = ERRD;
      end else begin
         is_err = 1'b0; exp_cyc = 1 + s_lat[tgt]; exp_rd = s_data[tgt];
      end
      got_cyc = -1; got_rd = '0; got_err = 1'b0; bad = 0;
      @(posedge clk); #1;
      up.valid = 1'b1; up.addr = a; up.wdata = wd; up.wstrb = ws;
      #1 slv_step();
      for (int c = 0; c < 400 && got_cyc < 0; c++) begin
         if (c > 0) begin @(posedge clk); #2 slv_step(); end
         @(negedge clk);
         exp_v = (c == 0 || tgt < 0) ? '0 : (one << tgt);
         if (s_vld !== exp_v) bad++;
         if (b_addr !== a || b_wdata !== wd || b_wstrb !== ws) bad++;
         if (up.ready === 1'b1) begin
            got_cyc = c; got_rd = up.rdata; got_err = err;
         end else if (up.rdata !== '0 || err !== 1'b0) begin
            bad++;
         end
      end
      chk("latency", got_cyc, exp_cyc);
      chk("rdata", got_rd, exp_rd);
      chk("err_o", got_err, is_err);
      chk("cycle_bad", bad, 0);
      @(posedge clk); #1 up.valid = 1'b0;
      #1 slv_step();
      if (is_err) begin
         m_err_addr = a;
         if (m_err_cnt < 255) m_err_cnt++;
      end
      @(negedge clk);
      chk("err_cnt", ecnt, m_err_cnt);
      chk("err_addr", eaddr, m_err_addr);
      chk("idle_quiet", {s_vld, up.ready}, '0);
   endtask

   task automatic ov_req(input logic [31:0] a);
      int tgt;
      logic [N-1:0] one;
      one = 1;
      tgt = ref_tgt(a, BASE_OV, MASK_OV);
      @(posedge clk); #1 up_ov.valid = 1'b1; up_ov.addr = a;
      @(negedge clk);
      chk("ov_decode_vld", ov_vld, '0);
      @(negedge clk);
      chk("ov_vld", ov_vld, one << tgt);
      chk("ov_ready", up_ov.ready, 1'b1);
      chk("ov_rdata", up_ov.rdata, 32'hA000_0000 + tgt);
      @(posedge clk); #1 up_ov.valid = 1'b0;
   endtask

   function automatic logic [31:0] rnd_addr(input int kind);
      logic [31:0] r;
      r = $urandom;
      case (kind)
         0: return 32'h1000_0000 | (r & 32'h00FF_00FF);
         1: return 32'h1000_1000 | (r & 32'h00FF_00FF);
         2: return 32'h4000_0000 | (r & 32'h0FFF_FFFF);
         3: return 32'h7000_0000 | (r & 32'h0FFF_FFFF);
         default: return r;
      endcase
   endfunction

   initial begin
      up.valid = 1'b0; up.addr = '0; up.wdata = '0; up.wstrb = '0;
      up_ov.valid = 1'b0; up_ov.addr = '0; up_ov.wdata = '0; up_ov.wstrb = '0;
      s_rdy = '0; s_data = '0;
      for (int i = 0; i < N; i++) begin s_lat[i] = 0; s_cnt[i] = 0; end

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_vld", s_vld, '0);
      chk("rst_ready", up.ready, 1'b0);
      chk("rst_rdata", up.rdata, '0);
      chk("rst_err", err, 1'b0);
      chk("rst_eaddr", eaddr, '0);
      chk("rst_ecnt", ecnt, '0);
      @(posedge clk); #1 rst = 1'b0;

      // Directed: mapped read, unmapped read
      s_lat[1] = 0; s_data[1] = 32'h1234_5678;
      do_req(32'h1000_1004, 32'h0, 4'h0);
      do_req(32'h7000_0000, 32'h0, 4'h0);

      // Hung slave, then ready exactly on the expiry cycle
      s_lat[2] = 20; s_data[2] = 32'h5555_AAAA;
      do_req(32'h4000_0010, 32'hCAFE_0001, 4'hF);
      s_lat[2] = TMO - 1; s_data[2] = 32'h0BAD_F00D;
      do_req(32'h4000_0020, 32'hCAFE_0002, 4'h3);

      // Overlapping windows resolve to the lowest index
      ov_req(32'h2000_0040);
      ov_req(32'h3000_0000);
      ov_req(32'h2100_0000);

      // Upstream abort in FWD
      s_lat[1] = 50;
      @(posedge clk); #1 up.valid = 1'b1; up.addr = 32'h1000_1000;
      #1 slv_step();
      repeat (2) begin @(posedge clk); #2 slv_step(); end
      @(negedge clk);
      chk("abort_pre_vld", s_vld, 3'b010);
      @(posedge clk); #1 up.valid = 1'b0;
      #1 slv_step();
      @(negedge clk);
      chk("abort_vld", s_vld, '0);
      chk("abort_ready", up.ready, 1'b0);
      @(posedge clk); #2 slv_step();
      @(negedge clk);
      chk("abort_idle_vld", s_vld, '0);
      chk("abort_ecnt", ecnt, m_err_cnt);
      s_lat[1] = 1; s_data[1] = 32'h0000_1111;
      do_req(32'h1000_1000, 32'h0, 4'h0);

      // Reset while forwarding
      s_lat[0] = 50;
      @(posedge clk); #1 up.valid = 1'b1; up.addr = 32'h1000_0000;
      #1 slv_step();
      repeat (3) begin @(posedge clk); #2 slv_step(); end
      @(negedge clk);
      chk("prerst_vld", s_vld, 3'b001);
      #2 rst = 1'b1;
      #1;
      chk("midrst_vld", s_vld, '0);
      chk("midrst_ready", up.ready, 1'b0);
      chk("midrst_ecnt", ecnt, '0);
      up.valid = 1'b0;
      m_err_cnt = 0; m_err_addr = '0;
      @(posedge clk); #1 rst = 1'b0;
      #1 slv_step();
      s_lat[0] = 2; s_data[0] = 32'h7777_0000;
      do_req(32'h1000_0008, 32'h0, 4'h0);

      // Randomized traffic
      for (int k = 0; k < 40; k++) begin
         int kind;
         kind = $urandom_range(0, 4);
         for (int i = 0; i < N; i++) begin
            s_lat[i]  = $urandom_range(0, 11);
            s_data[i] = $urandom;
         end
         do_req(rnd_addr(kind), $urandom, 4'($urandom_range(0, 15)));
      end

      // Error counter saturation
      for (int k = 0; k < 300; k++) do_req(rnd_addr(3), 32'h0, 4'h0);
      chk("err_cnt_sat", ecnt, 8'hFF);
      chk("ov_no_err", ecnt_ov, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/nmi_periph_router.md
# nmi_periph_router

Parametrised 1-to-N NMI address router. It replaces hand-written per-peripheral decode/OR-mux logic in the peripheral wrappers with a registered, table-driven router. It latches the target slave at request acceptance and forwards the transaction. Unmapped addresses and hung slaves receive an error response instead of stalling the core. It sits between the core-side NMI port and the native peripheral instances.

## Interface
Parameters:
- SLV_NUM, 11: number of downstream slaves (1..16).
- SLV_BASE, all 0: packed [SLV_NUM][32] base addresses.
- SLV_MASK, all 0: packed [SLV_NUM][32] compare masks. Slave i hits when (addr & SLV_MASK[i]) == SLV_BASE[i].
- TIMEOUT_CYC, 256: FWD cycles before a timeout error (>=2). Used only with the macro.
- ERR_DATA, 32'hDEAD_BEEF: rdata returned on any error response.

Ports:
- clk_i, in, 1: single clock.
- rst_i, in, 1: reset, asynchronous, active-high.
- nmi, nmi_if.slave: upstream request port.
- slv_nmi[SLV_NUM], nmi_if.master: downstream ports.
- err_o, out, 1: one-cycle pulse on any error response.
- err_addr_o, out, 32: address of the last errored request.
- err_cnt_o, out, 8: saturating error count.

## Operation
- FSM states: IDLE, FWD, DERR.
- IDLE, nmi.valid=1:
  - Compute the hit vector.
  - Any hit: latch sel = lowest hit index, then go to FWD. Overlapping windows resolve to the lowest index.
  - No hit: go to DERR.
- FWD:
  - Drive slv_nmi[sel].valid=1. All other slave valids are 0.
  - addr, wdata and wstrb are broadcast to all slaves.
  - When slv_nmi[sel].ready=1: assert nmi.ready=1 and nmi.rdata=slv_nmi[sel].rdata in the same cycle, then return to IDLE.
- DERR:
  - Assert nmi.ready=1 and rdata=ERR_DATA for exactly one cycle.
  - Pulse err_o, capture err_addr_o, increment err_cnt_o, return to IDLE.
- nmi.ready is asserted only in FWD-with-ready or DERR. Outside those cases nmi.rdata=0.
- Upstream valid dropping in FWD (protocol violation): abort, deassert slave valid, go to IDLE with no ready.
- err_cnt_o saturates at 8'hFF. It does not wrap.

## Timing
- Reset values:
  - state=IDLE, sel=0.
  - All slv_nmi valid=0; nmi.ready=0, nmi.rdata=0.
  - err_o=0, err_addr_o=0, err_cnt_o=0.
- Latency:
  - One decode cycle, so slave valid rises the cycle after upstream valid.
  - Response: nmi.ready appears in the slave's ready cycle.
  - Best case: 2 cycles from request to ready.
- Decode error: ready on the 2nd cycle after valid rises.
- Back-to-back requests: the master drops valid for at least the cycle after ready. IDLE accepts the next request immediately after that.
- Reset mid-operation: asynchronous return to IDLE. Any in-flight slave valid drops immediately.

## Configuration
- NMI_ROUTER_TIMEOUT_EN defined:
  - A timeout counter clears on FWD entry and increments each FWD cycle.
  - When it reaches TIMEOUT_CYC-1 with no slave ready: respond ready with ERR_DATA, pulse err_o, log the address, count the error, drop slave valid, go to IDLE.
  - A slave ready in the same cycle as expiry wins: a normal response, no error.
- Undefined: no counter. FWD waits for the slave indefinitely.

## Structure
- Package nmi_router_pkg:
  - State enum (IDLE/FWD/DERR).
  - ERR_DATA default.
  - A function computing the hit vector from addr, SLV_BASE and SLV_MASK.
- Sub-module nmi_router_tmo: the timeout counter and expiry flag. Instantiated only under the macro.

## Test plan
- SLV_NUM=3, windows 0x1000_0000/0x1000_1000/0x4000_0000 (mask FF00_FF00 for the first two), read 0x1000_1004. Expected: slv_nmi[1].valid one cycle after valid; slave ready with 0x1234_5678 gives nmi.ready, rdata=0x1234_5678; no other slave sees valid.
- Read 0x7000_0000 (unmapped). Expected: ready 2 cycles after valid, rdata=DEAD_BEEF, err_o pulse, err_addr_o=0x7000_0000, err_cnt_o=1.
- Macro on, TIMEOUT_CYC=8, slave never readies. Expected: error response after 8 FWD cycles, slave valid drops, err_cnt_o increments. Repeat with slave ready exactly on the expiry cycle: expected normal data and no err_o.
- Overlapping windows on slaves 0 and 2. Expected: slave 0 is selected.
- rst_i pulsed while in FWD. Expected: all valids and ready are 0 immediately. The next request then routes correctly.
- 300 unmapped accesses. Expected: err_cnt_o holds at 255.
